// File: rtl/fifo_pop_packer.sv
// fifo_pop_packer: pop-side drain stage for one FIFO channel, running on the FIFO pop clock.
// Pops bytes under flag control and packs four of them little-endian into a 32-bit valid/ready word.
module fifo_pop_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int CNT_W          = 16
) (
  input  logic             Pop_Clk,
  input  logic             Pop_Rst_n,
  input  logic [3:0]       POP_FLAG,
  input  logic [7:0]       DOUT,
  output logic             POP,
  input  logic             Drain,
  output logic [31:0]      Word_Out,
  output logic [3:0]       Word_Be,
  output logic             Word_Valid,
  input  logic             Word_Ready,
  output logic [CNT_W-1:0] Word_Count
);

  localparam logic [2:0] FULL_CNT  = 3'(BYTES_PER_WORD);
  localparam logic [3:0] FULL_PEND = 4'(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       count_q, count_d;
  logic [7:0]       lane_q [4];
  logic [7:0]       lane_d [4];
  logic             pop_q, pop_d;
  logic             cap_q, cap_d;
  logic [31:0]      word_q, word_d;
  logic [3:0]       be_q, be_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  logic             accept_s;
  logic             out_free_s;
  logic             flush_ok_s;
  logic             flag_ok_s;
  logic             room_s;
  logic [3:0]       pend_s;
  logic [31:0]      packed_s;

  function automatic logic [3:0] be_mask(input logic [2:0] n);
    logic [3:0] m;
    case (n)
      3'd1:    m = 4'h1;
      3'd2:    m = 4'h3;
      3'd3:    m = 4'h7;
      3'd4:    m = 4'hF;
      default: m = 4'h0;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] be_bits(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Capture, word assembly, output register load and pop decision.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lane_d     = lane_q;
    word_d     = word_q;
    be_d       = be_q;
    accept_s   = valid_q & Word_Ready;
    out_free_s = ~valid_q | Word_Ready;
    valid_d    = valid_q & ~Word_Ready;
    wcnt_d     = wcnt_q + {{(CNT_W-1){1'b0}}, accept_s};
    cap_d      = pop_q;
    flush_ok_s = 1'b0;
    flag_ok_s  = 1'b0;
    room_s     = 1'b0;
    pend_s     = 4'h0;
    packed_s   = 32'h0;

    if (cap_q) begin
      lane_d[count_q[1:0]] = DOUT;
      count_d = count_q + 3'd1;
    end else begin
      count_d = count_q;
    end

    packed_s   = {lane_d[3], lane_d[2], lane_d[1], lane_d[0]};
    flush_ok_s = (state_q == ST_FILL) & Drain & (POP_FLAG == 4'h0) & ~pop_q & ~cap_q
                 & (count_q != 3'd0) & out_free_s;

    case (state_q)
      ST_FILL, ST_HOLD: begin
        if (count_d == FULL_CNT) begin
          if (out_free_s) begin
            word_d  = packed_s;
            be_d    = 4'hF;
            valid_d = 1'b1;
            count_d = 3'd0;
            state_d = ST_FILL;
          end else begin
            state_d = ST_HOLD;
          end
        end else if (flush_ok_s) begin
          word_d  = packed_s & be_bits(be_mask(count_q));
          be_d    = be_mask(count_q);
          valid_d = 1'b1;
          count_d = 3'd0;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FLUSH: state_d = ST_FILL;
      default:  state_d = ST_FILL;
    endcase

    // The flag lags by a cycle, so a single entry must not be popped twice in a row.
    case (POP_FLAG)
      4'h0:    flag_ok_s = 1'b0;
      4'h1:    flag_ok_s = ~pop_q;
      default: flag_ok_s = 1'b1;
    endcase

    pend_s = {1'b0, count_d} + {3'b000, pop_q};
    if (pend_s < FULL_PEND) begin
      room_s = 1'b1;
    end else if ((pend_s == FULL_PEND) && !valid_d && (count_d != FULL_CNT)) begin
      room_s = 1'b1;
    end else begin
      room_s = 1'b0;
    end
    pop_d = flag_ok_s & room_s;
  end

  // State and datapath registers.
  always_ff @(posedge Pop_Clk or negedge Pop_Rst_n) begin
    if (!Pop_Rst_n) begin
      state_q <= ST_FILL;
      count_q <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= 8'h00;
      end
      pop_q   <= 1'b0;
      cap_q   <= 1'b0;
      word_q  <= 32'h0;
      be_q    <= 4'h0;
      valid_q <= 1'b0;
      wcnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lane_q  <= lane_d;
      pop_q   <= pop_d;
      cap_q   <= cap_d;
      word_q  <= word_d;
      be_q    <= be_d;
      valid_q <= valid_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign POP        = pop_q;
  assign Word_Out   = word_q;
  assign Word_Be    = be_q;
  assign Word_Valid = valid_q;
  assign Word_Count = wcnt_q;

endmodule

// File: tb/tb_fifo_pop_packer.sv
// Directed self-checking bench for fifo_pop_packer with a small behavioural FIFO pop-side model.
// The word counter is narrowed to 8 bits so that counter wrap is reachable in a short run.
module tb_fifo_pop_packer;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    flag_s;
  logic [7:0]    dout_r = 8'h00;
  logic          pop_s;
  logic          drain = 1'b0;
  logic [31:0]   word_s;
  logic [3:0]    be_s;
  logic          valid_s;
  logic          ready = 1'b0;
  logic [CW-1:0] wcnt_s;

  int            n_vec = 0;
  int            n_miss = 0;
  int            cyc = 0;
  int            push_n = 0;
  int            pop_n = 0;
  int            fill_s;
  int            underflows = 0;
  int            unstable = 0;
  int            back2back = 0;
  int            first_pop = -1;
  logic          single_mode = 1'b0;
  logic          prev_pop = 1'b0;
  logic          hold_p = 1'b0;
  logic [31:0]   hold_w = 32'h0;
  logic [3:0]    hold_be = 4'h0;
  logic [7:0]    mem [0:4095];
  logic [31:0]   rx_w [$];
  logic [3:0]    rx_be [$];
  int            rx_cyc [$];
  int            p0;
  int            dcyc;
  int            exp_cnt = 0;

  fifo_pop_packer #(.BYTES_PER_WORD(4), .CNT_W(CW)) dut (
    .Pop_Clk    (clk),
    .Pop_Rst_n  (rst_n),
    .POP_FLAG   (flag_s),
    .DOUT       (dout_r),
    .POP        (pop_s),
    .Drain      (drain),
    .Word_Out   (word_s),
    .Word_Be    (be_s),
    .Word_Valid (valid_s),
    .Word_Ready (ready),
    .Word_Count (wcnt_s)
  );

  always #5 clk = ~clk;

  assign fill_s = push_n - pop_n;
  assign flag_s = (fill_s > 15) ? 4'hF : fill_s[3:0];

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO pop side: the popped byte appears on DOUT the cycle after POP.
  always @(posedge clk) begin
    if (pop_s) begin
      if (push_n == pop_n) begin
        underflows <= underflows + 1;
      end else begin
        dout_r <= mem[pop_n % 4096];
        pop_n  <= pop_n + 1;
      end
    end
  end

  // Output stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_p   <= 1'b0;
      prev_pop <= 1'b0;
    end else begin
      if (valid_s && ready) begin
        rx_w.push_back(word_s);
        rx_be.push_back(be_s);
        rx_cyc.push_back(cyc);
      end
      if (hold_p && (word_s != hold_w || be_s != hold_be || !valid_s)) unstable <= unstable + 1;
      hold_p  <= valid_s && !ready;
      hold_w  <= word_s;
      hold_be <= be_s;
      if (single_mode && pop_s && prev_pop) back2back <= back2back + 1;
      prev_pop <= pop_s;
      if (pop_s && first_pop < 0) first_pop <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[push_n % 4096] = b;
    push_n = push_n + 1;
  endtask

  task automatic rx_clear();
    rx_w.delete();
    rx_be.delete();
    rx_cyc.delete();
  endtask

  initial begin
    step(1);
    check_val("rst_pop",   {31'h0, pop_s},   32'h0);
    check_val("rst_valid", {31'h0, valid_s}, 32'h0);
    check_val("rst_word",  word_s,           32'h0);
    check_val("rst_be",    {28'h0, be_s},    32'h0);
    check_val("rst_cnt",   {24'h0, wcnt_s},  32'h0);
    rst_n = 1'b1;
    step(2);

    // Eight bytes, consumer always ready.
    ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    step(25);
    exp_cnt = 2;
    check_val("s1_nwords", 32'(rx_w.size()), 32'd2);
    check_val("s1_w0",     rx_w[0],          32'h04030201);
    check_val("s1_be0",    {28'h0, rx_be[0]}, 32'hF);
    check_val("s1_w1",     rx_w[1],          32'h08070605);
    check_val("s1_be1",    {28'h0, rx_be[1]}, 32'hF);
    check_val("s1_cnt",    {24'h0, wcnt_s},  32'(exp_cnt));
    check_val("s1_latency", 32'(rx_cyc[0] - first_pop), 32'd5);
    check_val("s1_thruput", 32'(rx_cyc[1] - rx_cyc[0]), 32'd4);

    // Back-pressure: twelve bytes with the consumer stalled.
    rx_clear();
    ready = 1'b0;
    p0 = pop_n;
    for (int i = 0; i < 12; i++) push(8'(8'h10 + i));
    step(25);
    check_val("s2_pops_stall", 32'(pop_n - p0), 32'd8);
    check_val("s2_valid",      {31'h0, valid_s}, 32'h1);
    check_val("s2_word_held",  word_s, 32'h13121110);
    ready = 1'b1;
    step(25);
    exp_cnt = exp_cnt + 3;
    check_val("s2_nwords", 32'(rx_w.size()), 32'd3);
    check_val("s2_w0", rx_w[0], 32'h13121110);
    check_val("s2_w1", rx_w[1], 32'h17161514);
    check_val("s2_w2", rx_w[2], 32'h1B1A1918);
    check_val("s2_nobubble", 32'(rx_cyc[1] - rx_cyc[0]), 32'd1);
    check_val("s2_resume",   32'(rx_cyc[2] - rx_cyc[1]), 32'd5);
    check_val("s2_pops_all", 32'(pop_n - p0), 32'd12);
    check_val("s2_cnt", {24'h0, wcnt_s}, 32'(exp_cnt));

    // FIFO holding a single entry at a time.
    rx_clear();
    single_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h21 + i));
      step(2);
    end
    step(10);
    single_mode = 1'b0;
    exp_cnt = exp_cnt + 1;
    check_val("s3_back2back", 32'(back2back), 32'd0);
    check_val("s3_nwords", 32'(rx_w.size()), 32'd1);
    check_val("s3_w0", rx_w[0], 32'h24232221);

    // Partial word flushed by Drain.
    rx_clear();
    push(8'hAA);
    push(8'hBB);
    push(8'hCC);
    step(10);
    check_val("s4_no_early", {31'h0, valid_s}, 32'h0);
    drain = 1'b1;
    dcyc = cyc;
    step(10);
    exp_cnt = exp_cnt + 1;
    check_val("s4_nwords", 32'(rx_w.size()), 32'd1);
    check_val("s4_w0", rx_w[0], 32'h00CCBBAA);
    check_val("s4_be0", {28'h0, rx_be[0]}, 32'h7);
    check_val("s4_flush_lat", 32'(rx_cyc[0] - dcyc), 32'd1);
    drain = 1'b0;
    step(2);
    drain = 1'b1;
    step(10);
    drain = 1'b0;
    check_val("s4_empty_drain", 32'(rx_w.size()), 32'd1);
    check_val("s4_cnt", {24'h0, wcnt_s}, 32'(exp_cnt));

    // Asynchronous reset with a word pending and two bytes held.
    rx_clear();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h31 + i));
    step(15);
    check_val("s5_pending", word_s, 32'h34333231);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("s5_rst_pop",   {31'h0, pop_s},   32'h0);
    check_val("s5_rst_valid", {31'h0, valid_s}, 32'h0);
    check_val("s5_rst_word",  word_s,           32'h0);
    check_val("s5_rst_be",    {28'h0, be_s},    32'h0);
    check_val("s5_rst_cnt",   {24'h0, wcnt_s},  32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h41 + i));
    step(15);
    exp_cnt = 1;
    check_val("s5_nwords", 32'(rx_w.size()), 32'd1);
    check_val("s5_fresh",  rx_w[0], 32'h44434241);
    check_val("s5_cnt",    {24'h0, wcnt_s}, 32'(exp_cnt));

    // Counter wrap: 256 more words on an 8-bit counter.
    rx_clear();
    for (int j = 0; j < 1024; j++) push(8'(j));
    step(1100);
    check_val("s6_nwords", 32'(rx_w.size()), 32'd256);
    check_val("s6_first",  rx_w[0],   32'h03020100);
    check_val("s6_last",   rx_w[255], 32'hFFFEFDFC);
    check_val("s6_rate",   32'(rx_cyc[255] - rx_cyc[0]), 32'd1020);
    check_val("s6_wrap",   {24'h0, wcnt_s}, 32'h1);

    check_val("underflow", 32'(underflows), 32'd0);
    check_val("stability", 32'(unstable),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fifo_pop_packer.md
# fifo_pop_packer

Pop-side drain stage for one channel of the dual 1024x8 FIFO block. It issues `POP` to the FIFO under flag control, captures the 8-bit `DOUT` bytes and packs four consecutive bytes, little-endian, into a 32-bit word. Words are delivered on a valid/ready stream to the downstream consumer, with a drain request for emitting a partial word. It runs entirely in the FIFO pop-clock domain (`Pop_Clk0` or `Pop_Clk1` of the FIFO).

## Interface
Parameters:
- `BYTES_PER_WORD`, 4: bytes packed per output word. Fixed at 4; other values are unsupported.
- `CNT_W`, 16: width of the delivered-word counter.

Ports:
- `Pop_Clk  in  1`: single clock, the FIFO pop clock.
- `Pop_Rst_n  in  1`: reset, asynchronous, active-low.
- `POP_FLAG  in  4`: FIFO pop-side status.
  - 4'h0 = empty.
  - 4'h1 = exactly one entry.
  - ≥4'h2 = two or more entries.
- `DOUT  in  8`: FIFO read data.
- `POP  out  1`: FIFO pop strobe, registered.
- `Drain  in  1`: level; requests emission of held partial bytes once the FIFO is empty.
- `Word_Out  out  32`: packed word. Byte 0 (first popped) is at [7:0].
- `Word_Be  out  4`: byte enables for `Word_Out`, contiguous from bit 0.
- `Word_Valid  out  1`: output word valid.
- `Word_Ready  in  1`: consumer accepts when high with `Word_Valid`.
- `Word_Count  out  CNT_W`: number of words accepted; wraps modulo 2^CNT_W.

## Operation
- Reset (`Pop_Rst_n` low, asynchronous):
  - `POP`=0, `Word_Valid`=0, `Word_Out`=0, `Word_Be`=0, `Word_Count`=0.
  - Assembly count=0, in-flight flag=0, state=FILL.
- Read protocol: `POP` high in cycle t means `DOUT` carries the popped byte during t+1. The byte is captured at the end of t+1.
- Pop eligibility, evaluated each cycle:
  - `POP_FLAG`≥2: pop is allowed.
  - `POP_FLAG`==1: pop is allowed only if `POP` was low in the previous cycle, because the flag lags by one cycle.
  - `POP_FLAG`==0: no pop.
  - In every case, pop additionally requires held bytes + in-flight bytes < 4.
  - `Drain` does not suppress popping.
- Assembly: each captured byte is written to lane `count` and `count` increments.
  - When the 4th byte is captured and the output register is free (or is accepted in the same cycle), it goes straight into the output register. `Word_Be`=4'hF; count resets to 0.
  - If the output register is occupied and not accepted, the full assembly is held. Popping stops until the transfer happens.
- States:
  - FILL: normal popping.
  - HOLD: four bytes assembled and output busy. Moves to FILL on transfer.
  - FLUSH: entered from FILL when all of the following hold: `Drain`=1, `POP_FLAG`==0, no byte in flight, count>0, output register free.
    - FLUSH emits the partial word with `Word_Be` = (1<<count)-1 and unused lanes 0, then clears count and returns to FILL.
    - Lasts exactly one cycle.
- `Drain` with count==0 has no effect; an empty word is never emitted.
- Output handshake:
  - `Word_Out`, `Word_Be` and `Word_Valid` are stable while `Word_Valid`=1 and `Word_Ready`=0.
  - A transfer happens on a cycle with both high. `Word_Count` increments on that edge.
  - A new word may be loaded in the same cycle as an acceptance, with no bubble.
- Reset mid-operation: the held partial bytes and in-flight byte are discarded. The FIFO contents are not recovered.

## Timing
- Minimum latency: with `POP` in cycles 0–3 and `Word_Ready`=1, `Word_Valid` is high in cycle 5.
- Sustained throughput: one word per 4 cycles while `POP_FLAG`≥2 and `Word_Ready`=1. `POP` stays high continuously.
- Back-pressure:
  - Once a word is waiting in the output register, at most 4 further bytes are popped.
  - `POP` drops the cycle the 4th is issued.
  - `POP` resumes the cycle after the acceptance edge.
- With the FIFO at a single entry, consecutive pops are spaced at least 2 cycles apart.
- FLUSH output: `Word_Valid` rises the cycle after the FLUSH entry conditions are first met.

## Test plan
- Push 8 bytes 0x01..0x08, hold `Word_Ready`=1 → two words, 32'h04030201 then 32'h08070605, both with `Word_Be`=4'hF. `Word_Count`=2 and `POP` is never high while `POP_FLAG`==0.
- Keep `POP_FLAG`≥2 with `Word_Ready`=0 → exactly 8 pops occur, then `POP` stays low. `Word_Out` is held stable. Raise ready → the next word follows with no bubble.
- FIFO holding a single entry → `POP` is never high in two consecutive cycles, and no underflow occurs.
- Push 3 bytes 0xAA,0xBB,0xCC, then assert `Drain` → one word 32'h00CCBBAA with `Word_Be`=4'h7. A second `Drain` produces no output.
- Assert `Pop_Rst_n` low while 2 bytes are held and a word is pending → all outputs return to 0 asynchronously. After release the next 4 bytes form a fresh word.
- Accept 65537 words → `Word_Count` wraps to 1.
